bram_boot_loader_mem: RTL and testbench
=======================================

# bram_boot_loader_mem

Word-addressed boot memory that sits directly downstream of the AXI-to-BRAM controller on the boot-RAM path. Port A serves the controller's native BRAM interface with byte-enable writes and 1-cycle read latency. Port B is driven by an internal loader engine that either streams a boot image from a valid/ready source or zero-fills a region. This lets firmware be preloaded or scrubbed without the AXI fabric.

## Interface
- DATA_WIDTH, 64: data width of both ports, bits; a multiple of 8.
- MEM_ADDR_WIDTH, 13: word-index width; depth = 2^MEM_ADDR_WIDTH words.
- BRAM_ADDR_WIDTH, 19: byte-address width presented by the controller.

Clock is clk_i. Reset is rst_i, asynchronous and active-high.

- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- bram_en_a  in  1  port A enable
- bram_we_a  in  DATA_WIDTH/8  port A byte write strobes
- bram_addr_a  in  BRAM_ADDR_WIDTH  port A byte address
- bram_wrdata_a  in  DATA_WIDTH  port A write data
- bram_rddata_a  out  DATA_WIDTH  port A read data, registered
- ld_start_i  in  1  start pulse, sampled in IDLE only
- ld_clear_i  in  1  mode at start: 1 = zero-fill, 0 = stream load
- ld_base_i  in  MEM_ADDR_WIDTH  first word index
- ld_len_i  in  MEM_ADDR_WIDTH+1  word count, 0..2^MEM_ADDR_WIDTH
- ld_valid_i  in  1  stream beat valid
- ld_data_i  in  DATA_WIDTH  stream beat data
- ld_ready_o  out  1  stream beat accepted when valid & ready
- ld_busy_o  out  1  engine in CLEAR or LOAD
- ld_done_o  out  1  one-cycle completion pulse

## Operation
- Port A word index = bram_addr_a[MEM_ADDR_WIDTH+B-1:B], where B = log2(DATA_WIDTH/8); upper bits are ignored.
- Port A: with en=1, byte i is written when we[i]=1. The read is read-first (old data). bram_rddata_a holds its value while en=0.
- FSM states: IDLE, CLEAR, LOAD.
- IDLE: on ld_start_i, latch base, len and mode. Clear the word counter. Go to CLEAR if ld_clear_i=1, else LOAD. If len=0, stay in IDLE and pulse ld_done_o next cycle with no writes.
- LOAD: ld_ready_o=1 except on collision. Each accepted beat writes a full word at (base+cnt) mod 2^MEM_ADDR_WIDTH, then cnt++.
- CLEAR: writes zero at (base+cnt) every non-collision cycle, then cnt++. ld_valid_i is ignored and ld_ready_o=0.
- Termination: after the write with cnt=len-1, go to IDLE and pulse ld_done_o.
- Address wrap: the loader address wraps modulo depth. len=2^MEM_ADDR_WIDTH covers every word once.
- Collision: if port A has en=1, any we bit set, and the same word index as the loader's current address, the loader write is suppressed for that cycle. In that cycle ld_ready_o=0 and cnt holds; the loader retries next cycle. A port A read never stalls the loader.
- A port A read of a word the loader writes in the same cycle returns the old data.
- ld_start_i while busy is ignored.
- Reset mid-operation: FSM returns to IDLE with no done pulse. Memory contents are not reset; words already written stay.

## Timing
- Reset values: bram_rddata_a=0, ld_ready_o=0, ld_busy_o=0, ld_done_o=0, FSM=IDLE, cnt=0.
- Port A read latency is 1 cycle: address at edge t gives data valid after edge t+1.
- ld_start_i sampled at edge t: ld_busy_o=1 from t+1; in LOAD, ld_ready_o=1 from t+1.
- Each loader write commits at the accepting edge. It is visible to a port A read issued in the following cycle.
- CLEAR of N words takes N cycles plus collision stalls.
- The last write commits at edge t: ld_busy_o=0 and ld_done_o=1 during cycle t+1, low from t+2.
- ld_ready_o is combinational from FSM state, the loader address and the port A inputs.

## Structure
- Package bram_boot_pkg holds:
  - the FSM state enum (IDLE, CLEAR, LOAD);
  - the helper localparam for the byte-offset width B.
- Sub-module bram_tdp_byte is the true dual-port array: port A has byte strobes and a read-first registered output; port B is write-only, full word. It maps to Xilinx block RAM inference.
- Top level holds the FSM, counter, address adder, collision compare and done/busy logic.

## Test plan
- Port A byte write: bram_addr_a=0x18, we=0x0F, data=0x1122334455667788, then read 0x18 -> rddata[31:0]=0x55667788, upper bytes unchanged, 1 cycle after the read address.
- Stream load: base=0x10, len=4, beats D0..D3 with valid toggling every other cycle -> words 0x10..0x13 = D0..D3, exactly 4 handshakes, ld_done_o high 1 cycle after the 4th accept.
- Wrap and clear: base=2^13-2, len=4, clear=1 -> words 8190, 8191, 0, 1 = 0, neighbours untouched, done after 4 cycles.
- Collision: during LOAD at word 0x20, port A writes word 0x20 with we=0xFF -> ld_ready_o=0 that cycle, the loader word lands next cycle and the final value is the loader data. A port A read of 0x20 instead does not stall.
- len=0 and busy start: len=0 -> no writes, done pulse at t+1. A second ld_start_i during LOAD is ignored.
- Reset mid-LOAD after 2 of 5 beats -> outputs return to reset values, no done pulse, the 2 written words persist and are readable by port A.

Source files
------------

// File: rtl/bram_boot_pkg.sv
// Shared types and helpers for the boot-RAM loader memory.
// FSM state encoding and byte-offset width derivation.
package bram_boot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD
    } ld_state_t;

    function automatic int unsigned byte_off_width(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int unsigned BYTE_OFF_W = byte_off_width(64);

endpackage

// File: rtl/bram_tdp_byte.sv
// True dual-port block RAM: port A byte-strobed read-first with registered
// output, port B full-word write-only.
module bram_tdp_byte #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic                    b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata
);

    logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];

    // The top guarantees the two ports never write the same word in one cycle.
    always_ff @(posedge clk) begin
        if (a_en) begin
            for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
                if (a_we[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
        end else if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

endmodule

// File: rtl/bram_boot_loader_mem.sv
// Boot memory: AXI-BRAM controller on port A, stream-load / zero-fill engine
// on port B with collision-based back-off.
module bram_boot_loader_mem
    import bram_boot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MEM_ADDR_WIDTH  = 13,
    parameter int unsigned BRAM_ADDR_WIDTH = 19
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       bram_en_a,
    input  logic [DATA_WIDTH/8-1:0]    bram_we_a,
    input  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_a,
    input  logic [DATA_WIDTH-1:0]      bram_wrdata_a,
    output logic [DATA_WIDTH-1:0]      bram_rddata_a,
    input  logic                       ld_start_i,
    input  logic                       ld_clear_i,
    input  logic [MEM_ADDR_WIDTH-1:0]  ld_base_i,
    input  logic [MEM_ADDR_WIDTH:0]    ld_len_i,
    input  logic                       ld_valid_i,
    input  logic [DATA_WIDTH-1:0]      ld_data_i,
    output logic                       ld_ready_o,
    output logic                       ld_busy_o,
    output logic                       ld_done_o
);

    localparam int unsigned B = byte_off_width(DATA_WIDTH);

    ld_state_t                 state_q, state_d;
    logic [MEM_ADDR_WIDTH:0]   cnt_q, cnt_d, len_q, len_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [MEM_ADDR_WIDTH-1:0] a_idx, ld_addr;
    logic                      done_q, done_d;
    logic                      collide, wr_en;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      unused_addr_bits;

    assign a_idx            = bram_addr_a[MEM_ADDR_WIDTH+B-1:B];
    assign unused_addr_bits = ^{bram_addr_a[BRAM_ADDR_WIDTH-1:MEM_ADDR_WIDTH+B], bram_addr_a[B-1:0]};
    assign ld_addr          = base_q + cnt_q[MEM_ADDR_WIDTH-1:0];
    // Only a port A write to the same word backs the loader off; reads never do.
    assign collide          = bram_en_a && (|bram_we_a) && (a_idx == ld_addr);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        ld_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start_i) begin
                    base_d = ld_base_i;
                    len_d  = ld_len_i;
                    cnt_d  = '0;
                    if (ld_len_i == '0) begin
                        done_d = 1'b1;
                    end else if (ld_clear_i) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            CLEAR: begin
                wr_en = !collide;
            end
            LOAD: begin
                ld_ready_o = !collide;
                wr_en      = ld_valid_i && !collide;
                wr_data    = ld_data_i;
            end
            default: state_d = IDLE;
        endcase
        if (wr_en) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            base_q  <= base_d;
            done_q  <= done_d;
        end
    end

    assign ld_busy_o = (state_q != IDLE);
    assign ld_done_o = done_q;

    bram_tdp_byte #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_mem (
        .clk     (clk_i),
        .rst     (rst_i),
        .a_en    (bram_en_a),
        .a_we    (bram_we_a),
        .a_addr  (a_idx),
        .a_wdata (bram_wrdata_a),
        .a_rdata (bram_rddata_a),
        .b_we    (wr_en),
        .b_addr  (ld_addr),
        .b_wdata (wr_data)
    );

endmodule

// File: tb/tb_bram_boot_loader_mem.sv
// Self-checking bench for bram_boot_loader_mem: port A access, stream load,
// zero-fill with wrap, collisions, len=0, busy start and mid-load reset.
module tb_bram_boot_loader_mem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bram_en_a;
    logic [7:0]  bram_we_a;
    logic [18:0] bram_addr_a;
    logic [63:0] bram_wrdata_a;
    logic [63:0] bram_rddata_a;
    logic        ld_start_i, ld_clear_i, ld_valid_i;
    logic [12:0] ld_base_i;
    logic [13:0] ld_len_i;
    logic [63:0] ld_data_i;
    logic        ld_ready_o, ld_busy_o, ld_done_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] model [8192];
    logic [63:0] exp_q [$];
    logic [63:0] beats [4] = '{64'hD0D0_0000_1111_0000, 64'hD1D1_0001_2222_0001,
                               64'hD2D2_0002_3333_0002, 64'hD3D3_0003_4444_0003};

    bram_boot_loader_mem #(
        .DATA_WIDTH(64),
        .MEM_ADDR_WIDTH(13),
        .BRAM_ADDR_WIDTH(19)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
        .bram_wrdata_a(bram_wrdata_a), .bram_rddata_a(bram_rddata_a),
        .ld_start_i(ld_start_i), .ld_clear_i(ld_clear_i), .ld_base_i(ld_base_i),
        .ld_len_i(ld_len_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
        .ld_ready_o(ld_ready_o), .ld_busy_o(ld_busy_o), .ld_done_o(ld_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [18:0] baddr(input int w);
        return 19'(w) << 3;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input int w, input logic [7:0] we, input logic [63:0] data);
        bram_en_a = 1'b1; bram_we_a = we; bram_addr_a = baddr(w); bram_wrdata_a = data;
        for (int i = 0; i < 8; i++) if (we[i]) model[w][8*i +: 8] = data[8*i +: 8];
        tick;
        bram_en_a = 1'b0; bram_we_a = '0;
    endtask

    task automatic do_read(input int w, output logic [63:0] got);
        bram_en_a = 1'b1; bram_we_a = '0; bram_addr_a = baddr(w);
        tick;
        bram_en_a = 1'b0;
        got = bram_rddata_a;
    endtask

    task automatic start_ld(input bit clr, input int base, input int len);
        ld_start_i = 1'b1; ld_clear_i = clr; ld_base_i = 13'(base); ld_len_i = 14'(len);
        tick;
        ld_start_i = 1'b0; ld_clear_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < budget) begin
            if (ld_done_o) begin ok = 1'b1; break; end
            tick;
            n++;
        end
    endtask

    task automatic read_words(input string name, input int first, input int count);
        logic [63:0] got, exp;
        for (int i = 0; i < count; i++) begin
            int w = (first + i) % 8192;
            exp_q.push_back(model[w]);
            do_read(w, got);
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s word %0d: got %h expected %h", name, w, got, exp);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (bram_rddata_a !== '0) begin n_bad++; $display("FAIL reset_rddata: got %h expected 0", bram_rddata_a); end
        n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ld_ready_o); end
        n_cmp++; if (ld_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", ld_busy_o); end
        n_cmp++; if (ld_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", ld_done_o); end
        rst_i = 1'b0;
        tick;
    endtask

    task automatic test_full_clear;
        int n; bit ok;
        start_ld(1'b1, 0, 8192);
        n_cmp++; if (ld_busy_o !== 1'b1) begin n_bad++; $display("FAIL fill_busy: got %b expected 1", ld_busy_o); end
        wait_done(9000, n, ok);
        n_cmp++; if (!ok || n != 8192) begin n_bad++; $display("FAIL fill_cycles: got %0d (done=%b) expected 8192", n, ok); end
        for (int i = 0; i < 8192; i++) model[i] = '0;
        tick;
        n_cmp++; if (ld_done_o !== 1'b0) begin n_bad++; $display("FAIL fill_done_pulse: got %b expected 0", ld_done_o); end
        read_words("fill_read", 8190, 4);
    endtask

    task automatic test_byte_write;
        logic [63:0] got, exp;
        do_write(3, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        do_write(3, 8'h0F, 64'h11223344_55667788);
        exp_q.push_back(64'hDEADBEEF_55667788);
        do_read(3, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL byte_write: got %h expected %h", got, exp); end
        bram_addr_a = baddr(0);
        tick;
        n_cmp++; if (bram_rddata_a !== exp) begin n_bad++; $display("FAIL rd_hold: got %h expected %h", bram_rddata_a, exp); end
    endtask

    task automatic test_stream_load;
        int acc = 0, cyc = 0;
        bit fire;
        start_ld(1'b0, 'h10, 4);
        while (acc < 4 && cyc < 40) begin
            ld_valid_i = (cyc % 2 == 0);
            ld_data_i  = beats[acc];
            #1;
            fire = ld_valid_i && ld_ready_o;
            if (fire) model['h10 + acc] = beats[acc];
            tick;
            if (fire) acc++;
            cyc++;
        end
        n_cmp++; if (acc != 4 || cyc != 7) begin n_bad++; $display("FAIL stream_handshakes: got %0d accepts in %0d cycles expected 4 in 7", acc, cyc); end
        n_cmp++; if (ld_done_o !== 1'b1) begin n_bad++; $display("FAIL stream_done: got %b expected 1", ld_done_o); end
        ld_valid_i = 1'b1;
        #1;
        n_cmp++; if (ld_ready_o !== 1'b0 || ld_busy_o !== 1'b0) begin n_bad++; $display("FAIL stream_idle: got ready=%b busy=%b expected 0 0", ld_ready_o, ld_busy_o); end
        tick;
        ld_valid_i = 1'b0;
        n_cmp++; if (ld_done_o !== 1'b0) begin n_bad++; $display("FAIL stream_done_pulse: got %b expected 0", ld_done_o); end
        read_words("stream_read", 'h10, 4);
    endtask

    task automatic test_wrap_clear;
        int n; bit ok;
        for (int i = 0; i < 6; i++) do_write((8189 + i) % 8192, 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(i + 1));
        start_ld(1'b1, 8190, 4);
        wait_done(20, n, ok);
        for (int i = 0; i < 4; i++) model[(8190 + i) % 8192] = '0;
        n_cmp++; if (!ok || n != 4) begin n_bad++; $display("FAIL wrap_cycles: got %0d (done=%b) expected 4", n, ok); end
        tick;
        read_words("wrap_read", 8189, 6);
    endtask

    task automatic test_collision;
        logic [63:0] old;
        start_ld(1'b0, 'h20, 2);
        ld_valid_i = 1'b1; ld_data_i = 64'h1111_2222_3333_4444;
        bram_en_a = 1'b1; bram_we_a = 8'hFF; bram_addr_a = baddr('h20); bram_wrdata_a = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL coll_ready: got %b expected 0", ld_ready_o); end
        tick;
        bram_en_a = 1'b0; bram_we_a = '0;
        #1;
        n_cmp++; if (ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL coll_retry: got %b expected 1", ld_ready_o); end
        tick;
        model['h20] = 64'h1111_2222_3333_4444;
        old = model['h21];
        ld_data_i = 64'h5555_6666_7777_8888;
        bram_en_a = 1'b1; bram_addr_a = baddr('h21);
        #1;
        n_cmp++; if (ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL read_no_stall: got %b expected 1", ld_ready_o); end
        tick;
        bram_en_a = 1'b0; ld_valid_i = 1'b0;
        model['h21] = 64'h5555_6666_7777_8888;
        n_cmp++; if (bram_rddata_a !== old) begin n_bad++; $display("FAIL read_first: got %h expected %h", bram_rddata_a, old); end
        n_cmp++; if (ld_done_o !== 1'b1) begin n_bad++; $display("FAIL coll_done: got %b expected 1", ld_done_o); end
        tick;
        read_words("coll_read", 'h20, 2);
    endtask

    task automatic test_len0_busy;
        do_write('h30, 8'hFF, 64'h3030_3030_3030_3030);
        do_write('h50, 8'hFF, 64'h5050_5050_5050_5050);
        start_ld(1'b0, 'h30, 0);
        n_cmp++; if (ld_done_o !== 1'b1 || ld_busy_o !== 1'b0) begin n_bad++; $display("FAIL len0: got done=%b busy=%b expected 1 0", ld_done_o, ld_busy_o); end
        ld_valid_i = 1'b1; ld_data_i = 64'hEEEE_EEEE_EEEE_EEEE;
        tick;
        n_cmp++; if (ld_done_o !== 1'b0) begin n_bad++; $display("FAIL len0_pulse: got %b expected 0", ld_done_o); end
        start_ld(1'b0, 'h40, 2);
        ld_start_i = 1'b1; ld_clear_i = 1'b1; ld_base_i = 13'h50; ld_len_i = 14'd1;
        ld_data_i = 64'h4040_0000_0000_0001;
        tick;
        model['h40] = ld_data_i;
        ld_start_i = 1'b0; ld_clear_i = 1'b0;
        ld_data_i = 64'h4141_0000_0000_0002;
        tick;
        model['h41] = ld_data_i;
        ld_valid_i = 1'b0;
        n_cmp++; if (ld_done_o !== 1'b1) begin n_bad++; $display("FAIL busy_start_done: got %b expected 1", ld_done_o); end
        tick;
        read_words("len0_read", 'h30, 1);
        read_words("busy_start_read", 'h40, 2);
        read_words("busy_start_ignored", 'h50, 1);
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        do_write('h62, 8'hFF, 64'h6262_6262_6262_6262);
        start_ld(1'b0, 'h60, 5);
        ld_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ld_data_i = beats[i] ^ 64'hFFFF;
            model['h60 + i] = ld_data_i;
            tick;
        end
        ld_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        n_cmp++; if ({ld_busy_o, ld_ready_o, ld_done_o} !== 3'b000 || bram_rddata_a !== '0)
            begin n_bad++; $display("FAIL mid_reset: got busy=%b ready=%b done=%b rd=%h expected all 0", ld_busy_o, ld_ready_o, ld_done_o, bram_rddata_a); end
        tick;
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ld_done_o || ld_busy_o) seen = 1'b1;
            tick;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_reset_quiet: got done/busy activity expected none"); end
        read_words("mid_reset_read", 'h60, 3);
    endtask

    initial begin
        rst_i = 1'b1;
        bram_en_a = 1'b0; bram_we_a = '0; bram_addr_a = '0; bram_wrdata_a = '0;
        ld_start_i = 1'b0; ld_clear_i = 1'b0; ld_base_i = '0; ld_len_i = '0;
        ld_valid_i = 1'b0; ld_data_i = '0;
        test_reset;
        test_full_clear;
        test_byte_write;
        test_stream_load;
        test_wrap_clear;
        test_collision;
        test_len0_busy;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
